filter_iir_biquad_mc: RTL

// - Multi-channel, time-multiplexed direct-form-I biquad IIR filter core with an AXI4-Lite control slave.
// - One shared MAC serves N_CH channels; each channel keeps its own x/y history. Coefficients are common to all channels.
// - Sits behind the interconnect as the processing engine of the FilterIIR IP. Samples enter and leave on valid/ready stream ports.

---
 rtl/filter_iir_biquad_mc.sv | 335 +++++++++++++++++++++++++++++++++
 1 files changed

// File: rtl/filter_iir_biquad_mc.sv
// ============================================================================
// filter_iir_biquad_mc
// ----------------------------------------------------------------------------
// Multi-channel, time-multiplexed direct-form-I biquad IIR engine with an
// AXI4-Lite control slave. One shared multiplier/accumulator serves N_CH
// channels. Each channel keeps its own x1/x2/y1/y2 history. The five
// coefficients are shared by all channels.
//
//   y = (b0*x + b1*x1 + b2*x2 - a1*y1 - a2*y2) >>> FRAC_BITS
//
// Build option:
//   FILTER_IIR_SAT_EN  defined   -> out-of-range results clamp to the DATA_W
//                                   signed limits, and the clamped value
//                                   becomes y1.
//                      undefined -> results wrap to their low DATA_W bits.
//   In both builds an out-of-range result sets the sticky STATUS[1] flag.
//
// Ports:
//   ACLK, ARESET           clock, asynchronous active-high reset
//   S_AXI_*                AXI4-Lite slave, 32-bit data, AXI_AW-bit address
//   s_tdata/s_tchan        input sample and its channel number
//   s_tvalid/s_tready      input handshake
//   m_tdata/m_tchan        filtered sample and its channel number
//   m_tvalid/m_tready      output handshake
//
// Register map (byte offsets):
//   0x00 CTRL    [0] enable, [1] clear history + count (write-1, self-clearing)
//   0x04..0x14   B0, B1, B2, A1, A2 (COEF_W, sign-extended on read)
//   0x18 STATUS  [0] busy, [1] overflow (sticky, write-1-to-clear)
//   0x1C COUNT   completed outputs, 32-bit, wraps
// ============================================================================
module filter_iir_biquad_mc #(
    parameter int N_CH      = 4,
    parameter int DATA_W    = 16,
    parameter int COEF_W    = 16,
    parameter int FRAC_BITS = 14,
    parameter int AXI_AW    = 5,
    localparam int CH_W     = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic              ACLK,
    input  logic              ARESET,
    input  logic [AXI_AW-1:0] S_AXI_AWADDR,
    input  logic              S_AXI_AWVALID,
    output logic              S_AXI_AWREADY,
    input  logic [31:0]       S_AXI_WDATA,
    input  logic              S_AXI_WVALID,
    output logic              S_AXI_WREADY,
    output logic [1:0]        S_AXI_BRESP,
    output logic              S_AXI_BVALID,
    input  logic              S_AXI_BREADY,
    input  logic [AXI_AW-1:0] S_AXI_ARADDR,
    input  logic              S_AXI_ARVALID,
    output logic              S_AXI_ARREADY,
    output logic [31:0]       S_AXI_RDATA,
    output logic [1:0]        S_AXI_RRESP,
    output logic              S_AXI_RVALID,
    input  logic              S_AXI_RREADY,
    input  logic [DATA_W-1:0] s_tdata,
    input  logic [CH_W-1:0]   s_tchan,
    input  logic              s_tvalid,
    output logic              s_tready,
    output logic [DATA_W-1:0] m_tdata,
    output logic [CH_W-1:0]   m_tchan,
    output logic              m_tvalid,
    input  logic              m_tready
);

    localparam int PROD_W = DATA_W + COEF_W;
    localparam int ACC_W  = DATA_W + COEF_W + 3;
    localparam int WA_W   = AXI_AW - 2;

    localparam logic [WA_W-1:0] ADDR_CTRL   = WA_W'(0);
    localparam logic [WA_W-1:0] ADDR_B0     = WA_W'(1);
    localparam logic [WA_W-1:0] ADDR_B1     = WA_W'(2);
    localparam logic [WA_W-1:0] ADDR_B2     = WA_W'(3);
    localparam logic [WA_W-1:0] ADDR_A1     = WA_W'(4);
    localparam logic [WA_W-1:0] ADDR_A2     = WA_W'(5);
    localparam logic [WA_W-1:0] ADDR_STATUS = WA_W'(6);
    localparam logic [WA_W-1:0] ADDR_COUNT  = WA_W'(7);

    localparam logic signed [ACC_W-1:0] Y_MAX = {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] Y_MIN = {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

    typedef enum logic [1:0] {ST_IDLE, ST_MAC, ST_OUT} state_t;

    state_t state;

    logic                     ctrl_enable;
    logic signed [COEF_W-1:0] coef_b0, coef_b1, coef_b2, coef_a1, coef_a2;
    logic                     clear_pending;
    logic                     overflow;
    logic [31:0]              sample_count;
    logic [31:0]              rd_mux;

    logic signed [DATA_W-1:0] x1_hist [N_CH];
    logic signed [DATA_W-1:0] x2_hist [N_CH];
    logic signed [DATA_W-1:0] y1_hist [N_CH];
    logic signed [DATA_W-1:0] y2_hist [N_CH];

    // Per-sample snapshot: operands and coefficients frozen at accept time
    logic signed [DATA_W-1:0] x_s, x1_s, x2_s, y1_s, y2_s;
    logic signed [COEF_W-1:0] b0_s, b1_s, b2_s, a1_s, a2_s;
    logic [CH_W-1:0]          chan_q;
    logic                     chan_ok_q;
    logic                     in_chan_ok;
    logic [2:0]               mac_idx;
    logic signed [ACC_W-1:0]  acc;

    logic signed [COEF_W-1:0] mul_coef;
    logic signed [DATA_W-1:0] mul_data;
    logic signed [PROD_W-1:0] prod;
    logic signed [ACC_W-1:0]  prod_ext;
    logic signed [ACC_W-1:0]  acc_next;
    logic signed [ACC_W-1:0]  acc_shr;
    logic                     y_ovf;
    logic [DATA_W-1:0]        y_out;

    logic            wr_fire;
    logic [WA_W-1:0] wr_word;
    logic [WA_W-1:0] rd_word;
    logic            wr_clear;
    logic            wr_ovf_clr;
    logic            unused_ok;

    assign wr_fire       = S_AXI_AWVALID && S_AXI_WVALID && !S_AXI_BVALID;
    assign wr_word       = S_AXI_AWADDR[AXI_AW-1:2];
    assign rd_word       = S_AXI_ARADDR[AXI_AW-1:2];
    assign S_AXI_AWREADY = wr_fire;
    assign S_AXI_WREADY  = wr_fire;
    assign S_AXI_ARREADY = !S_AXI_RVALID;
    assign S_AXI_BRESP   = 2'b00;
    assign S_AXI_RRESP   = 2'b00;
    assign wr_clear      = wr_fire && (wr_word == ADDR_CTRL) && S_AXI_WDATA[1];
    assign wr_ovf_clr    = wr_fire && (wr_word == ADDR_STATUS) && S_AXI_WDATA[1];
    assign unused_ok     = &{1'b0, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0], S_AXI_WDATA};

    // A pending clear blocks new samples so the history is wiped before the next accept
    assign s_tready = (state == ST_IDLE) && ctrl_enable && !clear_pending;

    // Channel numbers that cannot address a history slot are still accepted but produce 0
    generate
        if (N_CH == (1 << CH_W)) begin : g_chan_full
            assign in_chan_ok = 1'b1;
        end else begin : g_chan_part
            assign in_chan_ok = (s_tchan < CH_W'(N_CH));
        end
    endgenerate

    // Shared MAC: one product per cycle in the order b0,b1,b2,a1,a2; feedback terms subtract
    always_comb begin
        mul_coef = '0;
        mul_data = '0;
        case (mac_idx)
            3'd0: begin mul_coef = b0_s; mul_data = x_s;  end
            3'd1: begin mul_coef = b1_s; mul_data = x1_s; end
            3'd2: begin mul_coef = b2_s; mul_data = x2_s; end
            3'd3: begin mul_coef = a1_s; mul_data = y1_s; end
            3'd4: begin mul_coef = a2_s; mul_data = y2_s; end
            default: ;
        endcase
        prod     = PROD_W'(mul_coef) * PROD_W'(mul_data);
        prod_ext = {{(ACC_W-PROD_W){prod[PROD_W-1]}}, prod};
        acc_next = (mac_idx >= 3'd3) ? (acc - prod_ext) : (acc + prod_ext);
    end

    // Final scaling: arithmetic shift floors toward -inf, then range check
    always_comb begin
        acc_shr = acc >>> FRAC_BITS;
        y_ovf   = (acc_shr > Y_MAX) || (acc_shr < Y_MIN);
`ifdef FILTER_IIR_SAT_EN
        if (acc_shr > Y_MAX)
            y_out = Y_MAX[DATA_W-1:0];
        else if (acc_shr < Y_MIN)
            y_out = Y_MIN[DATA_W-1:0];
        else
            y_out = acc_shr[DATA_W-1:0];
`else
        y_out = acc_shr[DATA_W-1:0];
`endif
    end

    // AXI write side: control and coefficient registers, single-beat B response
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            ctrl_enable  <= 1'b0;
            coef_b0      <= '0;
            coef_b1      <= '0;
            coef_b2      <= '0;
            coef_a1      <= '0;
            coef_a2      <= '0;
            S_AXI_BVALID <= 1'b0;
        end else if (wr_fire) begin
            S_AXI_BVALID <= 1'b1;
            case (wr_word)
                ADDR_CTRL: ctrl_enable <= S_AXI_WDATA[0];
                ADDR_B0:   coef_b0     <= S_AXI_WDATA[COEF_W-1:0];
                ADDR_B1:   coef_b1     <= S_AXI_WDATA[COEF_W-1:0];
                ADDR_B2:   coef_b2     <= S_AXI_WDATA[COEF_W-1:0];
                ADDR_A1:   coef_a1     <= S_AXI_WDATA[COEF_W-1:0];
                ADDR_A2:   coef_a2     <= S_AXI_WDATA[COEF_W-1:0];
                default: ;
            endcase
        end else if (S_AXI_BVALID && S_AXI_BREADY) begin
            S_AXI_BVALID <= 1'b0;
        end
    end

    // AXI read mux; unmapped offsets read as zero
    always_comb begin
        rd_mux = '0;
        case (rd_word)
            ADDR_CTRL:   rd_mux = {30'd0, clear_pending, ctrl_enable};
            ADDR_B0:     rd_mux = {{(32-COEF_W){coef_b0[COEF_W-1]}}, coef_b0};
            ADDR_B1:     rd_mux = {{(32-COEF_W){coef_b1[COEF_W-1]}}, coef_b1};
            ADDR_B2:     rd_mux = {{(32-COEF_W){coef_b2[COEF_W-1]}}, coef_b2};
            ADDR_A1:     rd_mux = {{(32-COEF_W){coef_a1[COEF_W-1]}}, coef_a1};
            ADDR_A2:     rd_mux = {{(32-COEF_W){coef_a2[COEF_W-1]}}, coef_a2};
            ADDR_STATUS: rd_mux = {30'd0, overflow, (state != ST_IDLE)};
            ADDR_COUNT:  rd_mux = sample_count;
            default: ;
        endcase
    end

    // AXI read side: data registered one cycle after the AR handshake
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            S_AXI_RVALID <= 1'b0;
            S_AXI_RDATA  <= '0;
        end else if (S_AXI_ARVALID && !S_AXI_RVALID) begin
            S_AXI_RVALID <= 1'b1;
            S_AXI_RDATA  <= rd_mux;
        end else if (S_AXI_RVALID && S_AXI_RREADY) begin
            S_AXI_RVALID <= 1'b0;
        end
    end

    // Sample engine FSM. MAC runs mac_idx 0..4 for the products, and mac_idx 5
    // scales the finished sum into the output register, so m_tvalid rises six
    // edges after the accept. Sticky-flag and clear-request sets come last so
    // they win over a same-cycle clear.
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            state         <= ST_IDLE;
            mac_idx       <= '0;
            acc           <= '0;
            x_s           <= '0;
            x1_s          <= '0;
            x2_s          <= '0;
            y1_s          <= '0;
            y2_s          <= '0;
            b0_s          <= '0;
            b1_s          <= '0;
            b2_s          <= '0;
            a1_s          <= '0;
            a2_s          <= '0;
            chan_q        <= '0;
            chan_ok_q     <= 1'b0;
            m_tvalid      <= 1'b0;
            m_tdata       <= '0;
            m_tchan       <= '0;
            clear_pending <= 1'b0;
            overflow      <= 1'b0;
            sample_count  <= '0;
            for (int i = 0; i < N_CH; i++) begin
                x1_hist[i] <= '0;
                x2_hist[i] <= '0;
                y1_hist[i] <= '0;
                y2_hist[i] <= '0;
            end
        end else begin
            if (wr_ovf_clr)
                overflow <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (clear_pending) begin
                        clear_pending <= 1'b0;
                        sample_count  <= '0;
                        for (int i = 0; i < N_CH; i++) begin
                            x1_hist[i] <= '0;
                            x2_hist[i] <= '0;
                            y1_hist[i] <= '0;
                            y2_hist[i] <= '0;
                        end
                    end else if (s_tvalid && s_tready) begin
                        x_s       <= s_tdata;
                        chan_q    <= s_tchan;
                        chan_ok_q <= in_chan_ok;
                        x1_s      <= in_chan_ok ? x1_hist[s_tchan] : '0;
                        x2_s      <= in_chan_ok ? x2_hist[s_tchan] : '0;
                        y1_s      <= in_chan_ok ? y1_hist[s_tchan] : '0;
                        y2_s      <= in_chan_ok ? y2_hist[s_tchan] : '0;
                        b0_s      <= coef_b0;
                        b1_s      <= coef_b1;
                        b2_s      <= coef_b2;
                        a1_s      <= coef_a1;
                        a2_s      <= coef_a2;
                        acc       <= '0;
                        mac_idx   <= '0;
                        state     <= ST_MAC;
                    end
                end
                ST_MAC: begin
                    if (mac_idx < 3'd5) begin
                        acc     <= acc_next;
                        mac_idx <= mac_idx + 3'd1;
                    end else begin
                        m_tdata  <= chan_ok_q ? y_out : '0;
                        m_tchan  <= chan_q;
                        m_tvalid <= 1'b1;
                        if (chan_ok_q && y_ovf)
                            overflow <= 1'b1;
                        state    <= ST_OUT;
                    end
                end
                ST_OUT: begin
                    if (m_tready) begin
                        m_tvalid     <= 1'b0;
                        sample_count <= sample_count + 32'd1;
                        if (chan_ok_q) begin
                            x2_hist[chan_q] <= x1_s;
                            x1_hist[chan_q] <= x_s;
                            y2_hist[chan_q] <= y1_s;
                            y1_hist[chan_q] <= m_tdata;
                        end
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
            if (wr_clear)
                clear_pending <= 1'b1;
        end
    end

endmodule
